// File: rtl/hub75_pkg.sv
// Shared constants, state encoding and word-map helper for the HUB75 panel scanner.
package hub75_pkg;

  localparam int PANEL_COLS    = 64;
  localparam int PANEL_ROWS    = 32;
  localparam int WORDS_PER_ROW = 3;
  localparam int FRAME_WORDS   = PANEL_ROWS * WORDS_PER_ROW;
  localparam int HALF_WORDS    = FRAME_WORDS / 2;
  localparam int NUM_PLANES    = 2 * WORDS_PER_ROW;
  localparam int COL_W         = $clog2(PANEL_COLS);

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } hub_ch_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_WAIT,
    ST_BLANK,
    ST_LATCH,
    ST_UNBLANK
  } hub_state_e;

  // First word of a top-half row: row * WORDS_PER_ROW, kept in 8 bits.
  function automatic logic [7:0] row_base(input logic [3:0] row);
    return {3'b000, row, 1'b0} + {4'b0000, row};
  endfunction

endpackage

// File: rtl/hub75_col_shifter.sv
// Six 64-bit colour plane registers and the HUB_clk phase generator for one line shift-out.
module hub75_col_shifter
  import hub75_pkg::*;
#(
  parameter int CLK_DIV = 2
)(
  input  logic        PNL_clk,
  input  logic        PNL_rst_n,
  input  logic        load,
  input  logic [2:0]  load_idx,
  input  logic [63:0] load_data,
  input  logic        start,
  output logic [5:0]  rgb,
  output logic        hub_clk,
  output logic        done
);

  localparam int                PH_W     = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_RISE  = PH_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(PANEL_COLS - 1);

  logic [NUM_PLANES-1:0][PANEL_COLS-1:0] plane;
  logic [PH_W-1:0]                       ph;
  logic [COL_W-1:0]                      col;
  logic                                  active;

  always_ff @(posedge PNL_clk) begin
    if (!PNL_rst_n) begin
      plane   <= '0;
      ph      <= '0;
      col     <= '0;
      active  <= 1'b0;
      hub_clk <= 1'b0;
    end else begin
      if (load) plane[load_idx] <= load_data;
      if (start) begin
        active  <= 1'b1;
        ph      <= '0;
        col     <= '0;
        hub_clk <= 1'b0;
      end else if (active) begin
        if (ph == PH_LAST) begin
          // end of the high phase: next column, clock back low
          ph      <= '0;
          hub_clk <= 1'b0;
          col     <= col + COL_W'(1);
          for (int i = 0; i < NUM_PLANES; i++) plane[i] <= plane[i] << 1;
          if (col == COL_LAST) active <= 1'b0;
        end else begin
          ph      <= ph + PH_W'(1);
          hub_clk <= (ph >= PH_RISE);
        end
      end
    end
  end

  assign rgb  = {plane[0][PANEL_COLS-1], plane[1][PANEL_COLS-1], plane[2][PANEL_COLS-1],
                 plane[3][PANEL_COLS-1], plane[4][PANEL_COLS-1], plane[5][PANEL_COLS-1]};
  assign done = active && (col == COL_LAST) && (ph == PH_LAST);

endmodule

// File: rtl/hub75_line_scanner.sv
// HUB75 1/16-scan line scanner reading pixel-plane words from the frame BRAM read port.
// Optional HUB75_DEADTIME_EN adds DEAD_CYCLES of extra blanking around each latch.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | held in reset; next cycle starts FETCH of line 0
// ST_FETCH   | 6 BRAM reads plus final capture (7 cycles)
// ST_SHIFT   | 64 columns clocked out on HUB_clk
// ST_WAIT    | previous line still owed on-time
// ST_BLANK   | HUB_oe high before latching
// ST_LATCH   | HUB_lat pulse
// ST_UNBLANK | new row address, on-time restarts, line advances
module hub75_line_scanner
  import hub75_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int ON_CYCLES   = 512,
  parameter int LINES       = 16
`ifdef HUB75_DEADTIME_EN
  ,
  parameter int DEAD_CYCLES = 4
`endif
)(
  input  logic        PNL_clk,
  input  logic        PNL_rst_n,
  output logic [7:0]  BRAM_addr,
  output logic        BRAM_rd_en,
  input  logic [63:0] BRAM_data,
  output logic        HUB_r1,
  output logic        HUB_g1,
  output logic        HUB_b1,
  output logic        HUB_r2,
  output logic        HUB_g2,
  output logic        HUB_b2,
  output logic        HUB_clk,
  output logic        HUB_lat,
  output logic        HUB_oe,
  output logic [3:0]  HUB_addr,
  output logic        frame_start
);

  localparam int             ON_W      = $clog2(ON_CYCLES + 1);
  localparam logic [7:0]     HALF_STEP = 8'(HALF_WORDS - WORDS_PER_ROW + 1);

  hub_state_e        state;
  logic [2:0]        fcnt;
  logic [3:0]        line;
  logic [3:0]        next_line;
  logic [3:0]        tgt_line;
  logic [ON_W-1:0]   on_cnt;
  logic              sh_load;
  logic [2:0]        sh_idx;
  logic              sh_start;
  logic              sh_done;
  logic [5:0]        sh_rgb;
`ifdef HUB75_DEADTIME_EN
  logic [7:0]        dcnt;
  logic [7:0]        dt_cnt;
`endif

  always_comb begin
    next_line = (line == 4'(LINES - 1)) ? 4'd0 : line + 4'd1;
    tgt_line  = (state == ST_UNBLANK) ? next_line : line;
  end

  // read issued in fetch cycle c is captured in cycle c+1
  assign sh_load  = (state == ST_FETCH) && (fcnt != 3'd0);
  assign sh_idx   = fcnt - 3'd1;
  assign sh_start = (state == ST_FETCH) && (fcnt == 3'd6);

  always_ff @(posedge PNL_clk) begin
    if (!PNL_rst_n) begin
      state       <= ST_IDLE;
      fcnt        <= '0;
      line        <= '0;
      on_cnt      <= '0;
      BRAM_addr   <= '0;
      BRAM_rd_en  <= 1'b0;
      frame_start <= 1'b0;
      HUB_lat     <= 1'b0;
      HUB_oe      <= 1'b1;
      HUB_addr    <= '0;
`ifdef HUB75_DEADTIME_EN
      dcnt        <= '0;
      dt_cnt      <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      if (on_cnt != '0) on_cnt <= on_cnt - ON_W'(1);
`ifdef HUB75_DEADTIME_EN
      if (dt_cnt != 8'd0) begin
        dt_cnt <= dt_cnt - 8'd1;
        if (dt_cnt == 8'd1) begin
          HUB_oe <= 1'b0;
          on_cnt <= ON_W'(ON_CYCLES);
        end
      end
`endif
      case (state)
        ST_IDLE, ST_UNBLANK: begin
          state       <= ST_FETCH;
          fcnt        <= '0;
          line        <= tgt_line;
          BRAM_rd_en  <= 1'b1;
          BRAM_addr   <= row_base(tgt_line);
          frame_start <= (tgt_line == 4'd0);
          if (state == ST_UNBLANK) begin
`ifdef HUB75_DEADTIME_EN
            if (DEAD_CYCLES == 0) begin
              HUB_oe <= 1'b0;
              on_cnt <= ON_W'(ON_CYCLES);
            end else begin
              dt_cnt <= 8'(DEAD_CYCLES);
            end
`else
            HUB_oe <= 1'b0;
            on_cnt <= ON_W'(ON_CYCLES);
`endif
          end
        end
        ST_FETCH: begin
          fcnt       <= fcnt + 3'd1;
          BRAM_rd_en <= (fcnt < 3'd5);
          if (fcnt < 3'd5)
            BRAM_addr <= BRAM_addr + ((fcnt == 3'(WORDS_PER_ROW - 1)) ? HALF_STEP : 8'd1);
          if (fcnt == 3'd6) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sh_done) begin
            // on_cnt <= 1 means the on-time is used up by the next cycle
            if (on_cnt <= ON_W'(1)) begin
              state  <= ST_BLANK;
              HUB_oe <= 1'b1;
`ifdef HUB75_DEADTIME_EN
              dcnt   <= 8'(DEAD_CYCLES);
`endif
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (on_cnt <= ON_W'(1)) begin
            state  <= ST_BLANK;
            HUB_oe <= 1'b1;
`ifdef HUB75_DEADTIME_EN
            dcnt   <= 8'(DEAD_CYCLES);
`endif
          end
        end
        ST_BLANK: begin
`ifdef HUB75_DEADTIME_EN
          if (dcnt != 8'd0) begin
            dcnt <= dcnt - 8'd1;
          end else begin
            state   <= ST_LATCH;
            HUB_lat <= 1'b1;
          end
`else
          state   <= ST_LATCH;
          HUB_lat <= 1'b1;
`endif
        end
        ST_LATCH: begin
          state    <= ST_UNBLANK;
          HUB_lat  <= 1'b0;
          HUB_addr <= line;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hub75_col_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_col_shifter (
    .PNL_clk   (PNL_clk),
    .PNL_rst_n (PNL_rst_n),
    .load      (sh_load),
    .load_idx  (sh_idx),
    .load_data (BRAM_data),
    .start     (sh_start),
    .rgb       (sh_rgb),
    .hub_clk   (HUB_clk),
    .done      (sh_done)
  );

  assign {HUB_r1, HUB_g1, HUB_b1, HUB_r2, HUB_g2, HUB_b2} = sh_rgb;

endmodule

// File: tb/tb_hub75_line_scanner.sv
// Directed bench for hub75_line_scanner: fetch addresses, shift-out, line timing, frame wrap, reset.
module tb_hub75_line_scanner;

`ifdef HUB75_DEADTIME_EN
  localparam int DT = 4;
`else
  localparam int DT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  baddr, baddr2;
  logic        brd, brd2;
  logic [63:0] bdata = '0, bdata2 = '0;
  logic        r1, g1, b1, r2, g2, b2, hclk, lat, oe, fs;
  logic [3:0]  haddr;
  logic        r1_2, g1_2, b1_2, r2_2, g2_2, b2_2, hclk2, lat2, oe2, fs2;
  logic [3:0]  haddr2;
  logic [63:0] mem [96];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hub75_line_scanner dut (
    .PNL_clk(clk), .PNL_rst_n(rst_n), .BRAM_addr(baddr), .BRAM_rd_en(brd), .BRAM_data(bdata),
    .HUB_r1(r1), .HUB_g1(g1), .HUB_b1(b1), .HUB_r2(r2), .HUB_g2(g2), .HUB_b2(b2),
    .HUB_clk(hclk), .HUB_lat(lat), .HUB_oe(oe), .HUB_addr(haddr), .frame_start(fs)
  );

  hub75_line_scanner #(.CLK_DIV(2), .ON_CYCLES(10), .LINES(16)) dut2 (
    .PNL_clk(clk), .PNL_rst_n(rst_n), .BRAM_addr(baddr2), .BRAM_rd_en(brd2), .BRAM_data(bdata2),
    .HUB_r1(r1_2), .HUB_g1(g1_2), .HUB_b1(b1_2), .HUB_r2(r2_2), .HUB_g2(g2_2), .HUB_b2(b2_2),
    .HUB_clk(hclk2), .HUB_lat(lat2), .HUB_oe(oe2), .HUB_addr(haddr2), .frame_start(fs2)
  );

  always @(posedge clk) begin
    if (brd)  bdata  <= (baddr  < 8'd96) ? mem[baddr]  : 64'd0;
    if (brd2) bdata2 <= (baddr2 < 8'd96) ? mem[baddr2] : 64'd0;
  end

  int   cyc2 = 0, last_lat2 = 0, per2 = 0, nlat2 = 0;
  logic lat2_d = 1'b0;
  always @(negedge clk) begin
    cyc2++;
    if (lat2 && !lat2_d) begin
      if (nlat2 > 0) per2 = cyc2 - last_lat2;
      last_lat2 = cyc2;
      nlat2++;
    end
    lat2_d = lat2;
  end

  function automatic logic [63:0] word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, ~b, b, ~b, b, ~b, b, ~b};
  endfunction

  function automatic logic [47:0] exp_addrs(input int l);
    int b;
    b = l * 3;
    return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 48), 8'(b + 49), 8'(b + 50)};
  endfunction

  function automatic logic [22:0] outs();
    return {oe, lat, hclk, r1, g1, b1, r2, g2, b2, brd, fs, haddr, baddr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the sample of FETCH cycle 0; returns on the next line's FETCH cycle 0.
  task automatic run_line(output logic [47:0] addrs, output int nrise, output logic [63:0] r1w,
                          output logic [63:0] b2w, output int nfs, output int nrd,
                          output int period, output int oe_low, output int oe_lead,
                          output int blank_run, output logic [3:0] unb_addr);
    int   c, run;
    logic prev_hclk, seen_low, saw_lat, done;
    addrs = '0; nrise = 0; r1w = '0; b2w = '0; nfs = 0; nrd = 0;
    oe_low = 0; oe_lead = 0; blank_run = -1; unb_addr = 4'hx;
    c = 0; run = 0; prev_hclk = 1'b0; seen_low = 1'b0; saw_lat = 1'b0; done = 1'b0;
    while (!done) begin
      if (brd) begin
        nrd++;
        if (c < 6) addrs[47 - 8 * c -: 8] = baddr;
      end
      if (fs) nfs++;
      if (!oe) begin
        oe_low++;
        seen_low = 1'b1;
        run = 0;
      end else begin
        if (!seen_low) oe_lead++;
        if (!lat) run++;
      end
      if (hclk && !prev_hclk) begin
        if (nrise < 64) begin
          r1w[63 - nrise] = r1;
          b2w[63 - nrise] = b2;
        end
        nrise++;
      end
      prev_hclk = hclk;
      if (saw_lat) begin
        unb_addr = haddr;
        done = 1'b1;
      end else if (lat) begin
        saw_lat = 1'b1;
        blank_run = run;
      end
      c++;
      @(negedge clk);
      if (!done && c > 3000) begin
        checks++;
        errors++;
        $error("FAIL line_timeout: observed %0d cycles expected latch within 3000", c);
        done = 1'b1;
      end
    end
    period = c;
  endtask

  task automatic check_line(input int k, input int l, input bit first);
    logic [47:0] addrs;
    logic [63:0] r1w, b2w;
    logic [3:0]  ua;
    int nrise, nfs, nrd, period, oe_low, oe_lead, blank_run;
    run_line(addrs, nrise, r1w, b2w, nfs, nrd, period, oe_low, oe_lead, blank_run, ua);
    chk($sformatf("fetch_addr_k%0d", k), 64'(addrs), 64'(exp_addrs(l)));
    chk($sformatf("rd_count_k%0d", k), 64'(nrd), 64'd6);
    chk($sformatf("hclk_rises_k%0d", k), 64'(nrise), 64'd64);
    chk($sformatf("frame_start_k%0d", k), 64'(nfs), (l == 0) ? 64'd1 : 64'd0);
    chk($sformatf("hub_addr_k%0d", k), 64'(ua), 64'(l));
    chk($sformatf("r1_word_k%0d", k), r1w, mem[3 * l]);
    chk($sformatf("b2_word_k%0d", k), b2w, mem[3 * l + 50]);
    chk($sformatf("period_k%0d", k), 64'(period), first ? 64'(266 + DT) : 64'(515 + 2 * DT));
    chk($sformatf("oe_low_k%0d", k), 64'(oe_low), first ? 64'd0 : 64'd512);
    if (!first) begin
      chk($sformatf("oe_after_unblank_k%0d", k), 64'(oe_lead), 64'(DT));
      chk($sformatf("blank_len_k%0d", k), 64'(blank_run), 64'(1 + DT));
    end
    if (l == 5) chk("row5_r1", r1w, 64'h8000_0000_0000_0001);
  endtask

  initial begin
    for (int a = 0; a < 96; a++) mem[a] = word(a);
    mem[15] = 64'h8000_0000_0000_0001;
    mem[16] = '0; mem[17] = '0; mem[63] = '0; mem[64] = '0; mem[65] = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs()), 64'h40_0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 17; k++) check_line(k, k % 16, k == 0);

    chk("dut2_lat_seen", 64'(nlat2 >= 3), 64'd1);
    chk("dut2_period", 64'(per2), 64'(266 + DT));

    repeat (100) @(negedge clk);
    chk("mid_shift_hclk_running", 64'(oe), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_shift", 64'(outs()), 64'h40_0000);
    rst_n = 1'b1;
    @(negedge clk);
    check_line(17, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
